// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays the stored color sequence back on the LEDs.
// Walks ROM addresses 0..limite; each value is lit for T_LIGADO cycles,
// followed by T_DESLIGADO dark cycles. pronto pulses once when the show ends.
//
// state   | meaning
// --------+--------------------------------------------------------------
// INICIAL | idle, endereco=0, waits for iniciar
// CARREGA | ROM data valid for endereco, captured into display register
// MOSTRA  | display register on leds for T_LIGADO cycles
// APAGA   | leds dark for T_DESLIGADO cycles, then advance or finish
// PROXIMO | new address presented to the ROM
// FIM     | pronto=1 for one cycle, then back to INICIAL
module exibe_sequencia #(
    parameter int T_LIGADO    = 1000,
    parameter int T_DESLIGADO = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int T_MAX = (T_LIGADO > T_DESLIGADO) ? T_LIGADO : T_DESLIGADO;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0] FIM_LIGADO    = TW'(T_LIGADO - 1);
    localparam logic [TW-1:0] FIM_DESLIGADO = TW'(T_DESLIGADO - 1);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        CARREGA = 4'd1,
        MOSTRA  = 4'd2,
        APAGA   = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    estado_t       estado;
    estado_t       proximo_estado;
    logic [TW-1:0] timer;
    logic [3:0]    limite_r;
    logic [3:0]    valor;

    logic fim_ligado;
    logic fim_desligado;
    logic ultimo;

    assign fim_ligado    = (timer == FIM_LIGADO);
    assign fim_desligado = (timer == FIM_DESLIGADO);
    assign ultimo        = (endereco == limite_r);
    assign db_estado     = estado;

    // State register; reset has priority over everything else.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo_estado;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        proximo_estado = INICIAL;
        leds           = 4'd0;
        ocupado        = (estado != INICIAL);
        pronto         = (estado == FIM);
        case (estado)
            INICIAL: proximo_estado = iniciar ? CARREGA : INICIAL;
            CARREGA: proximo_estado = MOSTRA;
            MOSTRA: begin
                leds           = valor;
                proximo_estado = fim_ligado ? APAGA : MOSTRA;
            end
            APAGA: begin
                if (fim_desligado) begin
                    proximo_estado = ultimo ? FIM : PROXIMO;
                end else begin
                    proximo_estado = APAGA;
                end
            end
            PROXIMO: proximo_estado = CARREGA;
            FIM:     proximo_estado = INICIAL;
            default: proximo_estado = INICIAL;
        endcase
    end

    // Address, timer, latched limit and display register.
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco <= 4'd0;
            timer    <= '0;
            limite_r <= 4'd0;
            valor    <= 4'd0;
        end else begin
            case (estado)
                INICIAL: begin
                    endereco <= 4'd0;
                    timer    <= '0;
                    if (iniciar) begin
                        limite_r <= limite;
                    end
                end
                CARREGA: begin
                    valor <= dado;
                    timer <= '0;
                end
                MOSTRA: begin
                    timer <= fim_ligado ? '0 : timer + 1'b1;
                end
                APAGA: begin
                    if (fim_desligado) begin
                        timer <= '0;
                        // the last address is kept so endereco never wraps past limite
                        if (!ultimo) begin
                            endereco <= endereco + 4'd1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PROXIMO: timer <= '0;
                FIM: begin
                    endereco <= 4'd0;
                    timer    <= '0;
                end
                default: begin
                    endereco <= 4'd0;
                    timer    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with a 1-cycle-latency ROM model.
module tb_exibe_sequencia;

    localparam int TL = 3;
    localparam int TD = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] mem [16];

    int n_assert = 0;
    int n_fail   = 0;
    int cnt_ocupado;
    int cnt_pronto;

    exibe_sequencia #(.T_LIGADO(TL), .T_DESLIGADO(TD)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Sync ROM: data follows the address by one clock.
    always @(posedge clock) dado <= mem[endereco];

    task automatic step();
        @(negedge clock);
        cnt_ocupado += int'(ocupado);
        cnt_pronto  += int'(pronto);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ciclo(input string tag, input int st, input int ld, input int ad);
        chk({tag, " estado"},   32'(db_estado), 32'(st));
        chk({tag, " leds"},     32'(leds),      32'(ld));
        chk({tag, " endereco"}, 32'(endereco),  32'(ad));
        chk({tag, " ocupado"},  32'(ocupado),   32'(st != 0));
        chk({tag, " pronto"},   32'(pronto),    32'(st == 5));
    endtask

    // Called at a negedge while idle; starts a show and checks every cycle.
    task automatic show(input string tag, input int lim, input bit disturb,
                        input bit hold, input int exp_ciclos);
        cnt_ocupado = 0;
        cnt_pronto  = 0;
        limite  = 4'(lim);
        iniciar = 1'b1;
        for (int i = 0; i <= lim; i++) begin
            step();
            if (!hold) iniciar = 1'b0;
            chk_ciclo({tag, " carrega"}, 1, 0, i);
            for (int k = 0; k < TL; k++) begin
                step();
                chk_ciclo({tag, " mostra"}, 2, int'(mem[i]), i);
                if (disturb && i == 1 && k == 0) begin
                    iniciar = 1'b1;
                    limite  = 4'd7;
                end
                if (disturb && i == 1 && k == 1) iniciar = 1'b0;
            end
            for (int k = 0; k < TD; k++) begin
                step();
                chk_ciclo({tag, " apaga"}, 3, 0, i);
            end
            if (i < lim) begin
                step();
                chk_ciclo({tag, " proximo"}, 4, 0, i + 1);
            end
        end
        step();
        chk_ciclo({tag, " fim"}, 5, 0, lim);
        chk({tag, " ciclos ocupado"}, 32'(cnt_ocupado), 32'(exp_ciclos));
        chk({tag, " pulsos pronto"},  32'(cnt_pronto),  32'd1);
    endtask

    initial begin
        int guard;
        reset   = 1'b1;
        iniciar = 1'b0;
        limite  = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        repeat (3) @(negedge clock);
        chk_ciclo("reset", 0, 0, 0);
        reset = 1'b0;
        step();
        chk_ciclo("idle", 0, 0, 0);

        // Basic show, four elements.
        mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
        show("basico", 3, 1'b0, 1'b0, 28);
        step();
        chk_ciclo("basico pos", 0, 0, 0);

        // Single element.
        show("lim0", 0, 1'b0, 1'b0, 7);
        step();
        chk_ciclo("lim0 pos", 0, 0, 0);

        // Full ROM, value 0 at address 0 shown as a dark on-time.
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        show("lim15", 15, 1'b0, 1'b0, 112);
        step();
        chk_ciclo("lim15 pos", 0, 0, 0);

        // Reset during MOSTRA of element 2.
        limite  = 4'd3;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        guard = 0;
        while (!(db_estado == 4'd2 && endereco == 4'd2) && guard < 100) begin
            step();
            guard++;
        end
        chk("aborto alcancou mostra2", 32'(guard < 100), 32'd1);
        reset = 1'b1;
        step();
        chk_ciclo("aborto", 0, 0, 0);
        reset = 1'b0;
        cnt_pronto = 0;
        repeat (20) step();
        chk("aborto sem pronto", 32'(cnt_pronto), 32'd0);
        chk_ciclo("aborto idle", 0, 0, 0);
        show("replay", 3, 1'b0, 1'b0, 28);
        step();

        // iniciar and limite disturbed mid-show.
        mem[0] = 4'd9; mem[1] = 4'd6; mem[2] = 4'd3;
        show("perturba", 2, 1'b1, 1'b0, 21);
        step();
        chk_ciclo("perturba pos", 0, 0, 0);

        // Reset wins over iniciar.
        reset   = 1'b1;
        iniciar = 1'b1;
        step();
        chk_ciclo("reset+iniciar", 0, 0, 0);
        step();
        chk_ciclo("reset+iniciar 2", 0, 0, 0);
        reset   = 1'b0;
        iniciar = 1'b0;
        step();
        chk_ciclo("reset+iniciar pos", 0, 0, 0);

        // iniciar held high: back-to-back shows with one INICIAL cycle.
        show("seguido1", 1, 1'b0, 1'b1, 14);
        step();
        chk_ciclo("seguido intervalo", 0, 0, 0);
        show("seguido2", 1, 1'b0, 1'b0, 14);
        step();
        chk_ciclo("seguido pos", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
